healt_bar_damage_controller: RTL
================================

HEALT_BAR_DAMAGE_CONTROLLER -- requirements
Module: healt_bar_damage_controller

Interface
REQ-001 Parameter CENTI_PER_REGEN, default 100: centi-second ticks between regen steps; used only when HEALT_REGEN_EN is defined.
REQ-002 Parameter W_BITS, default 10: width of all health-width ports.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1: system clock; all state changes on its rising edge.
REQ-005 clk_reset  input  1: synchronous, active-low reset.
REQ-006 clk_centi_second  input  1: one-clk-wide pulse, 100 Hz time base.
REQ-007 reset_healt_status  input  1: one-clk load strobe from the UI runtime.
REQ-008 healt_bar_w  input  W_BITS: full bar width; sampled on load only.
REQ-009 healt_bar_w_minus  input  W_BITS: damage per hit; sampled at the hit cycle.
REQ-010 healt_bar_sensitivity  input  7: invulnerability window in centi-seconds; sampled at the hit cycle.
REQ-011 is_trigger_player  input  1: level collision flag from the trigger runtime.
REQ-012 healt_bar_cur_w  output  W_BITS: current bar width, registered.
REQ-013 hit_pulse  output  1: one-clk pulse per accepted hit.
REQ-014 invuln  output  1: high while in COOLDOWN.
REQ-015 is_dead  output  1: high while in DEAD.

Function
REQ-016 FSM states: IDLE, ALIVE, COOLDOWN, DEAD; all outputs are registered.
REQ-017 Load is reset_healt_status=1 in any state:
- next cycle, healt_bar_cur_w=healt_bar_w, cooldown counter=0;
- state ALIVE if healt_bar_w!=0, else DEAD.
REQ-018 Load has priority over a hit, a tick or a regen step in the same cycle; hit_pulse stays 0 in that cycle.
REQ-019 Hit is is_trigger_player=1 in ALIVE:
- next cycle, cur_w = saturating cur_w - w_minus, floor 0;
- hit_pulse=1 for exactly one cycle.
REQ-020 After a hit:
- if new cur_w=0, state DEAD;
- else if sensitivity=0, state ALIVE;
- else state COOLDOWN with counter=sensitivity.
REQ-021 A hit with w_minus=0 still pulses hit_pulse and enters cooldown; width is unchanged.
REQ-022 COOLDOWN:
- is_trigger_player is ignored;
- on each clk_centi_second the counter decrements;
- when the counter goes 1->0, the next state is ALIVE.
REQ-023 Cooldown exit latency: window ends on the sensitivity-th tick after the hit; a collision held high re-hits on the first ALIVE cycle.
REQ-024 A tick coincident with the hit cycle is not counted.
REQ-025 IDLE and DEAD ignore is_trigger_player and ticks; they exit only via load or reset.
REQ-026 is_dead=1 iff state DEAD; invuln=1 iff state COOLDOWN.

Reset
REQ-027 clk_reset=0 at a rising edge SHALL force, regardless of state or any in-flight cooldown:
- state IDLE;
- healt_bar_cur_w=0, hit_pulse=0, invuln=0, is_dead=0;
- cooldown and regen counters 0.
REQ-028 Reset overrides load and hit in the same cycle.

Configuration
REQ-029 Macro HEALT_REGEN_EN, when defined, SHALL add regen:
- in ALIVE, a regen counter counts ticks;
- every CENTI_PER_REGEN ticks, cur_w increments by 1, saturating at the latched full width;
- counter clears on hit, load and reset;
- no regen in COOLDOWN, DEAD or IDLE.
REQ-030 Without HEALT_REGEN_EN:
- no regen counter is synthesized;
- cur_w never increases except by load.

Verification
REQ-031 Reset low 3 cycles, then high -> cur_w=0, state IDLE; a collision in IDLE produces no hit_pulse.
REQ-032 Load w=200, then collision with w_minus=30, sens=5 -> cur_w=170, one hit_pulse, invuln for exactly 5 ticks; the collision held through cooldown gives a second hit on the first ALIVE cycle, cur_w=140.
REQ-033 cur_w=20, w_minus=50 -> cur_w=0, is_dead=1; later collisions and ticks change nothing; load w=100 -> ALIVE, cur_w=100.
REQ-034 Load and collision in the same cycle -> cur_w=w, no hit_pulse; sens=0 hit -> state ALIVE next cycle, invuln never asserts.
REQ-035 Reset asserted mid-COOLDOWN (counter=3) -> IDLE and all outputs 0 next cycle.
REQ-036 HEALT_REGEN_EN, CENTI_PER_REGEN=4, cur_w=198, full=200 -> +1 after 4 ticks, +1 after 8 ticks, stays 200 after 12 ticks; without the macro, cur_w stays 198.

Source files
------------

// File: rtl/healt_bar_damage_controller.sv
// Health bar damage controller: load, hit with saturating damage, invulnerability cooldown, death.
// Optional regeneration in ALIVE is enabled by defining HEALT_REGEN_EN.
module healt_bar_damage_controller #(
    parameter int unsigned CENTI_PER_REGEN = 100,
    parameter int unsigned W_BITS          = 10
) (
    input  logic              clk,
    input  logic              clk_reset,
    input  logic              clk_centi_second,
    input  logic              reset_healt_status,
    input  logic [W_BITS-1:0] healt_bar_w,
    input  logic [W_BITS-1:0] healt_bar_w_minus,
    input  logic [6:0]        healt_bar_sensitivity,
    input  logic              is_trigger_player,
    output logic [W_BITS-1:0] healt_bar_cur_w,
    output logic              hit_pulse,
    output logic              invuln,
    output logic              is_dead
);

    localparam int unsigned CD_W = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIVE,
        S_COOLDOWN,
        S_DEAD
    } state_t;

    if (CENTI_PER_REGEN == 0) begin : g_bad_cfg
        $error("CENTI_PER_REGEN must be nonzero");
    end

    state_t            state;
    state_t            state_next;
    logic [W_BITS-1:0] cur_w_next;
    logic [CD_W-1:0]   cd_cnt;
    logic [CD_W-1:0]   cd_cnt_next;
    logic              hit_c;
    logic              regen_step_c;

`ifdef HEALT_REGEN_EN
    localparam int unsigned RW = (CENTI_PER_REGEN > 1) ? $clog2(CENTI_PER_REGEN) : 1;

    logic [RW-1:0]     regen_cnt;
    logic [W_BITS-1:0] full_w;
    logic              regen_wrap_c;

    // Regen counter runs only on non-hit ticks in ALIVE; full width is latched at load.
    always_ff @(posedge clk) begin
        if (!clk_reset) begin
            regen_cnt <= '0;
            full_w    <= '0;
        end else if (reset_healt_status) begin
            regen_cnt <= '0;
            full_w    <= healt_bar_w;
        end else if (state == S_ALIVE) begin
            if (is_trigger_player) begin
                regen_cnt <= '0;
            end else if (clk_centi_second) begin
                regen_cnt <= regen_wrap_c ? '0 : regen_cnt + RW'(1);
            end
        end
    end

    always_comb begin
        regen_wrap_c = clk_centi_second && (regen_cnt == RW'(CENTI_PER_REGEN - 1));
        regen_step_c = (state == S_ALIVE) && !is_trigger_player && regen_wrap_c
                       && (healt_bar_cur_w < full_w);
    end
`else
    assign regen_step_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clk_reset) begin
            state           <= S_IDLE;
            healt_bar_cur_w <= '0;
            cd_cnt          <= '0;
            hit_pulse       <= 1'b0;
            invuln          <= 1'b0;
            is_dead         <= 1'b0;
        end else begin
            state           <= state_next;
            healt_bar_cur_w <= cur_w_next;
            cd_cnt          <= cd_cnt_next;
            hit_pulse       <= hit_c;
            invuln          <= (state_next == S_COOLDOWN);
            is_dead         <= (state_next == S_DEAD);
        end
    end

    // Load beats everything; otherwise hits in ALIVE, tick countdown in COOLDOWN.
    always_comb begin
        state_next  = state;
        cur_w_next  = healt_bar_cur_w;
        cd_cnt_next = cd_cnt;
        hit_c       = 1'b0;
        if (reset_healt_status) begin
            cur_w_next  = healt_bar_w;
            cd_cnt_next = '0;
            state_next  = (healt_bar_w != '0) ? S_ALIVE : S_DEAD;
        end else begin
            case (state)
                S_ALIVE: begin
                    if (is_trigger_player) begin
                        hit_c      = 1'b1;
                        cur_w_next = (healt_bar_cur_w > healt_bar_w_minus)
                                     ? healt_bar_cur_w - healt_bar_w_minus : '0;
                        if (cur_w_next == '0) begin
                            state_next = S_DEAD;
                        end else if (healt_bar_sensitivity == '0) begin
                            state_next = S_ALIVE;
                        end else begin
                            state_next  = S_COOLDOWN;
                            cd_cnt_next = healt_bar_sensitivity;
                        end
                    end else if (regen_step_c) begin
                        cur_w_next = healt_bar_cur_w + W_BITS'(1);
                    end
                end
                S_COOLDOWN: begin
                    if (clk_centi_second) begin
                        cd_cnt_next = cd_cnt - CD_W'(1);
                        if (cd_cnt == CD_W'(1)) begin
                            state_next = S_ALIVE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
